// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one single-port RAM between two requesters
// Optional RAM_ARB_LOCK_EN adds m0_lock/m1_lock with a MAX_LOCK consecutive-grant cap.
module ram_port_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef RAM_ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic [1:0]        arm_q;
   logic              grant_ok;
   logic              last_owner;
   logic              prio1;
   logic              rd_push;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_id;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   // Grants stay off until reset release has been synchronised to clk.
   assign grant_ok = arm_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q <= 2'b00;
      end else begin
         arm_q <= {arm_q[0], 1'b1};
      end
   end

`ifdef RAM_ARB_LOCK_EN
   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   logic [CNT_W-1:0] lock_cnt;
   logic             owner_hold;
   logic             gnt_lock;

   // A nonzero count means the previous grant was a locked grant to last_owner.
   always_comb begin
      owner_hold = 1'b0;
      if (lock_cnt != '0 && lock_cnt < CNT_W'(MAX_LOCK)) begin
         owner_hold = last_owner ? (m1_req & m1_lock) : (m0_req & m0_lock);
      end
   end

   assign prio1    = owner_hold ? last_owner : ~last_owner;
   assign gnt_lock = (m0_gnt & m0_lock) | (m1_gnt & m1_lock);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
      end else if (gnt_lock) begin
         if (m1_gnt == last_owner && lock_cnt != '0) begin
            if (lock_cnt != CNT_W'(MAX_LOCK)) begin
               lock_cnt <= lock_cnt + 1'b1;
            end
         end else begin
            lock_cnt <= CNT_W'(1);
         end
      end else begin
         lock_cnt <= '0;
      end
   end
`else
   assign prio1 = ~last_owner;
`endif

   assign m0_gnt    = grant_ok & m0_req & (~m1_req | ~prio1);
   assign m1_gnt    = grant_ok & m1_req & (~m0_req | prio1);
   assign ram_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
   assign ram_addr  = m0_gnt ? m0_addr  : (m1_gnt ? m1_addr  : addr_q);
   assign ram_wdata = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : wdata_q);
   assign rd_push   = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else if (m0_gnt | m1_gnt) begin
         last_owner <= m1_gnt;
         addr_q     <= ram_addr;
         wdata_q    <= ram_wdata;
      end
   end

   // Read-return tags travel alongside the RAM's own read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v  <= '0;
         pipe_id <= '0;
      end else begin
         pipe_v[0]  <= rd_push;
         pipe_id[0] <= m1_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end
      end
   end

   assign m0_rvalid = pipe_v[RD_LAT-1] & ~pipe_id[RD_LAT-1];
   assign m1_rvalid = pipe_v[RD_LAT-1] &  pipe_id[RD_LAT-1];
   assign m0_rdata  = m0_rvalid ? ram_rdata : rdata0_q;
   assign m1_rdata  = m1_rvalid ? ram_rdata : rdata1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (m0_rvalid) begin
            rdata0_q <= ram_rdata;
         end
         if (m1_rvalid) begin
            rdata1_q <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
   localparam int AW   = 13;
   localparam int DW   = 32;
   localparam int LAT  = 1;
   localparam int MAXL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef RAM_ARB_LOCK_EN
   logic          m0_lock, m1_lock;
`endif

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_LOCK(MAXL)) u_dut (
      .clk(clk), .rst_n(rst_n),
`ifdef RAM_ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Behavioural single-port RAM, write-first, LAT-cycle read.
   logic          mem_clr;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rpipe [LAT];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      rpipe[0] <= ram_we ? ram_wdata : mem[ram_addr];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[LAT-1];

   typedef struct { int due; bit port; logic [DW-1:0] data; } ret_t;
   typedef struct {
      bit r0; bit w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
      bit r1; bit w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
      bit g0; bit g1;
   } vec_t;

   ret_t          rq[$];
   logic [DW-1:0] exp_mem [int];
   logic [DW-1:0] exp_rd0, exp_rd1;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wdata;
   bit            mdl_last;
   int            total = 0, bad = 0, cyc = 0;
   logic          s_g0, s_g1, s_v0, s_v1;
   logic [DW-1:0] s_d0, s_d1;
   vec_t          tab[12];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mrd(input int a);
      return exp_mem.exists(a) ? exp_mem[a] : '0;
   endfunction

   // One clock of checking against the reference model, then advance.
   task automatic step();
      bit e0, e1, ev0, ev1;
      ret_t r;
      @(negedge clk);
      e0 = m0_req && (!m1_req || mdl_last);
      e1 = m1_req && (!m0_req || !mdl_last);
      s_g0 = m0_gnt; s_g1 = m1_gnt; s_v0 = m0_rvalid; s_v1 = m1_rvalid;
      s_d0 = m0_rdata; s_d1 = m1_rdata;
      chk("gnt0", 32'(m0_gnt), 32'(e0));
      chk("gnt1", 32'(m1_gnt), 32'(e1));
      if (e0) begin h_addr = m0_addr; h_wdata = m0_wdata; end
      else if (e1) begin h_addr = m1_addr; h_wdata = m1_wdata; end
      chk("ram_we", 32'(ram_we), 32'((e0 && m0_we) || (e1 && m1_we)));
      chk("ram_addr", 32'(ram_addr), 32'(h_addr));
      chk("ram_wdata", ram_wdata, h_wdata);
      ev0 = 0; ev1 = 0;
      while (rq.size() > 0 && rq[0].due == cyc) begin
         r = rq.pop_front();
         if (r.port) begin ev1 = 1; exp_rd1 = r.data; end
         else begin ev0 = 1; exp_rd0 = r.data; end
      end
      chk("rvalid0", 32'(m0_rvalid), 32'(ev0));
      chk("rvalid1", 32'(m1_rvalid), 32'(ev1));
      chk("rdata0", m0_rdata, exp_rd0);
      chk("rdata1", m1_rdata, exp_rd1);
      if (e0) begin
         if (m0_we) exp_mem[int'(m0_addr)] = m0_wdata;
         else rq.push_back('{cyc + LAT, 1'b0, mrd(int'(m0_addr))});
         mdl_last = 0;
      end else if (e1) begin
         if (m1_we) exp_mem[int'(m1_addr)] = m1_wdata;
         else rq.push_back('{cyc + LAT, 1'b1, mrd(int'(m1_addr))});
         mdl_last = 1;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, 32'({m1_gnt, m0_gnt}), 32'd0);
      chk({tag, "_rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'd0);
      chk({tag, "_rdata0"}, m0_rdata, '0);
      chk({tag, "_rdata1"}, m1_rdata, '0);
      chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_wdata"}, ram_wdata, '0);
   endtask

   task automatic do_reset();
      rst_n = 0; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
      @(negedge clk);
      chk_all_zero("rst");
      @(posedge clk); #1;
      rst_n = 1;
      repeat (3) @(posedge clk);
      #1;
      mdl_last = 1; h_addr = '0; h_wdata = '0; exp_rd0 = '0; exp_rd1 = '0;
      rq.delete();
      cyc = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      bit p0, p1, got, seen_rv;
      m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
      m0_lock = 0; m1_lock = 0;
`endif
      mem_clr = 1;
      do_reset();
      mem_clr = 0;

      // Alternation under contention, single-port grants, back-to-back and idle.
      for (int i = 0; i < 6; i++)
         tab[i] = '{1'b1, 1'b0, 13'h10, 32'h0, 1'b1, 1'b1, 13'h20, 32'h12345678, (i % 2) == 0, (i % 2) == 1};
      tab[6]  = '{1'b0, 1'b0, 13'h0,  32'h0, 1'b1, 1'b0, 13'h20, 32'h0, 1'b0, 1'b1};
      tab[7]  = '{1'b1, 1'b0, 13'h30, 32'h0, 1'b1, 1'b0, 13'h40, 32'h0, 1'b1, 1'b0};
      tab[8]  = '{1'b1, 1'b0, 13'h31, 32'h0, 1'b1, 1'b0, 13'h40, 32'h0, 1'b0, 1'b1};
      tab[9]  = '{1'b1, 1'b0, 13'h31, 32'h0, 1'b0, 1'b0, 13'h0,  32'h0, 1'b1, 1'b0};
      tab[10] = '{1'b1, 1'b0, 13'h32, 32'h0, 1'b0, 1'b0, 13'h0,  32'h0, 1'b1, 1'b0};
      tab[11] = '{1'b0, 1'b0, 13'h0,  32'h0, 1'b0, 1'b0, 13'h0,  32'h0, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         m0_req = tab[i].r0; m0_we = tab[i].w0; m0_addr = tab[i].a0; m0_wdata = tab[i].d0;
         m1_req = tab[i].r1; m1_we = tab[i].w1; m1_addr = tab[i].a1; m1_wdata = tab[i].d1;
         step();
         chk($sformatf("tab%0d_g0", i), 32'(s_g0), 32'(tab[i].g0));
         chk($sformatf("tab%0d_g1", i), 32'(s_g1), 32'(tab[i].g1));
      end
      chk("ram20", mem[13'h20], 32'h12345678);

      // Write then immediate read of the same word by port 1.
      m1_req = 1; m1_we = 1; m1_addr = 13'h100; m1_wdata = 32'hA5A5A5A5;
      step();
      chk("raw_wgnt", 32'(s_g1), 32'd1);
      m1_we = 0;
      step();
      chk("raw_rgnt", 32'(s_g1), 32'd1);
      m1_req = 0;
      step();
      chk("raw_rvalid", 32'(s_v1), 32'd1);
      chk("raw_rdata", s_d1, 32'hA5A5A5A5);

      // Fresh reset, then a single read of a known word.
      m0_req = 1; m0_we = 1; m0_addr = 13'h5; m0_wdata = 32'hDEADBEEF;
      step();
      do_reset();
      m0_req = 1; m0_we = 0; m0_addr = 13'h5;
      step();
      chk("rd1_gnt", 32'(s_g0), 32'd1);
      m0_req = 0;
      step();
      chk("rd1_rvalid0", 32'(s_v0), 32'd1);
      chk("rd1_rdata0", s_d0, 32'hDEADBEEF);
      chk("rd1_rvalid1", 32'(s_v1), 32'd0);

      // Randomised traffic obeying the hold-until-granted handshake.
      p0 = 0; p1 = 0;
      for (int n = 0; n < 400; n++) begin
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1; m0_we = 1'($urandom_range(0, 1));
            m0_addr = AW'($urandom_range(0, 15)); m0_wdata = $urandom;
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1; m1_we = 1'($urandom_range(0, 1));
            m1_addr = AW'($urandom_range(0, 15)); m1_wdata = $urandom;
         end
         m0_req = p0; m1_req = p1;
         step();
         if (s_g0) p0 = 0;
         if (s_g1) p1 = 0;
      end
      m0_req = 0; m1_req = 0;
      repeat (LAT + 1) step();

      // Reset while a read is in flight and both ports are requesting.
      m0_req = 1; m0_we = 0; m0_addr = 13'h5;
      step();
      chk("mid_gnt", 32'(s_g0), 32'd1);
      m1_req = 1; m1_we = 0; m1_addr = 13'h7;
      rst_n = 0;
      @(negedge clk);
      chk_all_zero("mid");
      @(posedge clk); #1;
      rst_n = 1;
      got = 0; seen_rv = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (m0_rvalid || m1_rvalid) seen_rv = 1;
         if (m0_gnt || m1_gnt) begin
            got = 1;
            chk("mid_first_gnt", 32'({m1_gnt, m0_gnt}), 32'd1);
         end
         @(posedge clk); #1;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL mid_timeout got=no_grant want=grant");
      end
      chk("mid_no_rvalid", 32'(seen_rv), 32'd0);

`ifdef RAM_ARB_LOCK_EN
      do_reset();
      m0_lock = 1;
      m0_req = 1; m0_we = 0; m0_addr = 13'h1;
      m1_req = 1; m1_we = 0; m1_addr = 13'h2;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("lock%0d", k), 32'({m1_gnt, m0_gnt}), (k == 4) ? 32'd2 : 32'd1);
         @(posedge clk); #1;
      end
      m0_req = 0; m1_req = 0; m0_lock = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
